// File: rtl/booth_pe_r4.sv
// booth_pe_r4: systolic PE, out = value*active_weight (+ inp_west, saturated) via iterative radix-4 Booth; ports: clk, rst_overall_n (sync, low), clr_acc, in_valid/in_ready/value/inp_west/mode west side, out_valid/out_ready/outp_east east side, wt_load/wt_update_en/wt_data/wt_swap double-buffered weight, sat_flag sticky clamp flag
module booth_pe_r4 #(
  parameter int DATAWIDTH = 11,
  parameter int COLUMNS = 64,
  parameter int ACCW = 2*DATAWIDTH + $clog2(COLUMNS),
  parameter int NSTEP = (DATAWIDTH+1)/2
) (
  input  logic                 clk,
  input  logic                 rst_overall_n,
  input  logic                 clr_acc,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] value,
  input  logic [ACCW-1:0]      inp_west,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACCW-1:0]      outp_east,
  input  logic                 wt_load,
  input  logic                 wt_update_en,
  input  logic [DATAWIDTH-1:0] wt_data,
  input  logic                 wt_swap,
  output logic                 sat_flag
);
  localparam int PW = 2*DATAWIDTH;
  localparam int BW = 2*NSTEP + 1;
  localparam int CW = $clog2(NSTEP+1);
  typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;
  state_t state;
  logic signed [PW-1:0] a_sh, a2, pp, prod, prod_nxt;
  logic [BW-1:0] b_sh;
  logic [2:0] d;
  logic [CW-1:0] step;
  logic [1:0] mode_q;
  logic [ACCW-1:0] west_q, res;
  logic [DATAWIDTH-1:0] active, shadow, wsat;
  logic [DATAWIDTH:0] wsum;
  logic signed [ACCW:0] sum;
  logic mul_only, ovf;
  assign in_ready = state == IDLE;
  always_comb begin
    d = b_sh[2:0];
    a2 = a_sh <<< 1;
    pp = (d == 3'b001 || d == 3'b010) ? a_sh :
         d == 3'b011 ? a2 :
         d == 3'b100 ? -a2 :
         (d == 3'b101 || d == 3'b110) ? -a_sh : '0;
    prod_nxt = prod + pp;
    sum = (ACCW+1)'(prod_nxt) + (ACCW+1)'($signed(west_q));
    ovf = sum[ACCW] ^ sum[ACCW-1];
    mul_only = mode_q == 2'b10;
    res = mul_only ? ACCW'(prod_nxt) : ovf ? {sum[ACCW], {(ACCW-1){~sum[ACCW]}}} : sum[ACCW-1:0];
    wsum = (DATAWIDTH+1)'($signed(shadow)) + (DATAWIDTH+1)'($signed(wt_data));
    wsat = (wsum[DATAWIDTH] ^ wsum[DATAWIDTH-1]) ? {wsum[DATAWIDTH], {(DATAWIDTH-1){~wsum[DATAWIDTH]}}} : wsum[DATAWIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_overall_n) begin
      active <= '0;
      shadow <= '0;
    end else begin
      if (wt_swap) active <= shadow;
      if (wt_load) shadow <= wt_data;
      else if (wt_update_en) shadow <= wsat;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_overall_n) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      prod <= '0;
      step <= '0;
      mode_q <= '0;
      west_q <= '0;
      outp_east <= '0;
      out_valid <= 1'b0;
      sat_flag <= 1'b0;
    end else if (clr_acc) begin
      state <= IDLE;
      outp_east <= '0;
      out_valid <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh <= PW'($signed(value));
          b_sh <= {(2*NSTEP)'($signed(active)), 1'b0};
          west_q <= inp_west;
          mode_q <= mode;
          prod <= '0;
          step <= '0;
          if (mode == 2'b01) begin
            outp_east <= inp_west;
            out_valid <= 1'b1;
            state <= OUT;
          end else state <= MUL;
        end
        MUL: begin
          prod <= prod_nxt;
          a_sh <= a_sh <<< 2;
          b_sh <= {{2{b_sh[BW-1]}}, b_sh[BW-1:2]};
          step <= step + CW'(1);
          if (step == CW'(NSTEP-1)) begin
            outp_east <= res;
            out_valid <= 1'b1;
            sat_flag <= sat_flag | (~mul_only & ovf);
            state <= OUT;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
